fmul_issue_ctrl: RTL and testbench



---
 rtl/fmul_issue_ctrl_pkg.sv | 15 +
 rtl/fmul_issue_ctrl_rr_arbiter.sv | 32 +++
 rtl/fpMult.sv | 63 ++++++
 rtl/fmul_issue_ctrl.sv | 136 +++++++++++++
 tb/tb_fmul_issue_ctrl.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/fmul_issue_ctrl_pkg.sv
// Shared definitions for the FP multiply issue controller: default sizing,
// canonical IEEE-754 constants and a pointer-width helper.
package fmul_issue_ctrl_pkg;

    localparam int unsigned NUM_RS_DEF = 3;
    localparam int unsigned TAG_W_DEF  = 4;

    localparam logic [31:0] FP_QNAN    = 32'h7FFF_FFFF;
    localparam logic [31:0] FP_POS_INF = 32'h7F80_0000;

    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fmul_issue_ctrl_rr_arbiter.sv
// Round-robin arbiter: grants the first requester strictly after ptr,
// searching cyclically; grant is one-hot or zero when en is low.
module rr_arbiter
    import fmul_issue_ctrl_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0]              req,
    input  logic [ptr_width(N)-1:0]   ptr,
    input  logic                      en,
    output logic [N-1:0]              grant
);

    int unsigned base;
    int unsigned idx;
    logic        found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        base  = 32'(ptr);
        idx   = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = (base + k) % N;
            if (en && !found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpMult.sv
// Combinational IEEE-754 single-precision multiplier; round-to-nearest-even,
// subnormal inputs and underflowing results flush to signed zero.
module fpMult
    import fmul_issue_ctrl_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] p
);

    logic        sign;
    logic [7:0]  ea, eb;
    logic [23:0] ma, mb;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [47:0] prod;
    logic [22:0] mant;
    logic        guard, sticky;
    logic [23:0] rnd;
    int          e;

    assign sign   = a[31] ^ b[31];
    assign ea     = a[30:23];
    assign eb     = b[30:23];
    assign ma     = {1'b1, a[22:0]};
    assign mb     = {1'b1, b[22:0]};
    assign a_nan  = (ea == 8'hFF) && (a[22:0] != '0);
    assign b_nan  = (eb == 8'hFF) && (b[22:0] != '0);
    assign a_inf  = (ea == 8'hFF) && (a[22:0] == '0);
    assign b_inf  = (eb == 8'hFF) && (b[22:0] == '0);
    assign a_zero = (ea == 8'h00);
    assign b_zero = (eb == 8'h00);

    always_comb begin
        prod = 48'(ma) * 48'(mb);
        // Product of two [1,2) significands lies in [1,4): normalise on bit 47.
        if (prod[47]) begin
            mant   = prod[46:24];
            guard  = prod[23];
            sticky = |prod[22:0];
            e      = 32'(ea) + 32'(eb) - 126;
        end else begin
            mant   = prod[45:23];
            guard  = prod[22];
            sticky = |prod[21:0];
            e      = 32'(ea) + 32'(eb) - 127;
        end
        rnd = {1'b0, mant} + 24'(guard & (sticky | mant[0]));
        if (rnd[23]) begin
            e = e + 1;
        end

        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
            p = FP_QNAN;
        end else if (a_inf || b_inf || (e >= 255)) begin
            p = {sign, FP_POS_INF[30:0]};
        end else if (a_zero || b_zero || (e <= 0)) begin
            p = {sign, 31'b0};
        end else begin
            p = {sign, 8'(e), rnd[22:0]};
        end
    end

endmodule

// File: rtl/fmul_issue_ctrl.sv
// Issue/writeback controller for the shared FP multiplier: round-robin issue
// from the reservation stations, LAT-cycle stallable pipeline onto the CDB.
module fmul_issue_ctrl
    import fmul_issue_ctrl_pkg::*;
#(
    parameter int unsigned NUM_RS = NUM_RS_DEF,
    parameter int unsigned TAG_W  = TAG_W_DEF,
    parameter int unsigned LAT    = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_RS-1:0]       rs_req,
    input  logic [NUM_RS*TAG_W-1:0] rs_tag,
    input  logic [NUM_RS*32-1:0]    rs_op_a,
    input  logic [NUM_RS*32-1:0]    rs_op_b,
    output logic [NUM_RS-1:0]       rs_grant,
    input  logic                    flush,
    output logic                    cdb_valid,
    output logic [TAG_W-1:0]        cdb_tag,
    output logic [31:0]             cdb_data,
    input  logic                    cdb_ready,
    output logic                    busy
);

    localparam int unsigned PW = ptr_width(NUM_RS);

    logic             advance, grant_en;
    logic [PW-1:0]    last_ptr, win_idx;
    logic [TAG_W-1:0] win_tag;
    logic [31:0]      win_a, win_b;

    logic             s0_valid;
    logic [TAG_W-1:0] s0_tag;
    logic [31:0]      s0_a, s0_b, product;

    logic             st_valid [1:LAT-1];
    logic [TAG_W-1:0] st_tag   [1:LAT-1];
    logic [31:0]      st_data  [1:LAT-1];

    assign advance  = !cdb_valid || cdb_ready;
    assign grant_en = rst_n && advance && !flush;

    rr_arbiter #(.N(NUM_RS)) u_arb (
        .req   (rs_req),
        .ptr   (last_ptr),
        .en    (grant_en),
        .grant (rs_grant)
    );

    always_comb begin
        win_idx = '0;
        win_tag = '0;
        win_a   = '0;
        win_b   = '0;
        for (int unsigned i = 0; i < NUM_RS; i++) begin
            if (rs_grant[i]) begin
                win_idx = PW'(i);
                win_tag = rs_tag[i*TAG_W +: TAG_W];
                win_a   = rs_op_a[i*32 +: 32];
                win_b   = rs_op_b[i*32 +: 32];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_valid <= 1'b0;
            s0_tag   <= '0;
            s0_a     <= '0;
            s0_b     <= '0;
            last_ptr <= PW'(NUM_RS - 1);
        end else if (flush) begin
            s0_valid <= 1'b0;
        end else if (advance) begin
            s0_valid <= |rs_grant;
            s0_tag   <= win_tag;
            s0_a     <= win_a;
            s0_b     <= win_b;
            if (|rs_grant) begin
                last_ptr <= win_idx;
            end
        end
    end

    fpMult u_fmul (
        .a (s0_a),
        .b (s0_b),
        .p (product)
    );

    for (genvar g = 1; g < LAT; g++) begin : g_stage
        logic             in_valid, v;
        logic [TAG_W-1:0] in_tag, t;
        logic [31:0]      in_data, d;

        if (g == 1) begin : g_head
            assign in_valid = s0_valid;
            assign in_tag   = s0_tag;
            assign in_data  = product;
        end else begin : g_tail
            assign in_valid = st_valid[g-1];
            assign in_tag   = st_tag[g-1];
            assign in_data  = st_data[g-1];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v <= 1'b0;
                t <= '0;
                d <= '0;
            end else if (flush) begin
                v <= 1'b0;
            end else if (advance) begin
                v <= in_valid;
                t <= in_tag;
                d <= in_data;
            end
        end

        assign st_valid[g] = v;
        assign st_tag[g]   = t;
        assign st_data[g]  = d;
    end

    assign cdb_valid = st_valid[LAT-1];
    assign cdb_tag   = st_tag[LAT-1];
    assign cdb_data  = st_data[LAT-1];

    always_comb begin
        busy = s0_valid;
        for (int unsigned k = 1; k < LAT; k++) begin
            busy = busy | st_valid[k];
        end
    end

endmodule

// File: tb/tb_fmul_issue_ctrl.sv
// Scoreboard bench for fmul_issue_ctrl: directed issues push expected CDB
// results; a negedge monitor compares every presented result in order.
module tb_fmul_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  rs_req;
    logic [11:0] rs_tag;
    logic [95:0] rs_op_a, rs_op_b;
    logic [2:0]  rs_grant;
    logic        flush;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        cdb_ready;
    logic        busy;

    typedef struct packed {
        logic [3:0]  tag;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [3:0]  st_tag [3];
    logic [31:0] st_a   [3];
    logic [31:0] st_b   [3];
    logic [31:0] st_exp [3];
    logic [2:0]  sticky;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    assign rs_tag  = {st_tag[2], st_tag[1], st_tag[0]};
    assign rs_op_a = {st_a[2], st_a[1], st_a[0]};
    assign rs_op_b = {st_b[2], st_b[1], st_b[0]};

    fmul_issue_ctrl #(.NUM_RS(3), .TAG_W(4), .LAT(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rs_req    (rs_req),
        .rs_tag    (rs_tag),
        .rs_op_a   (rs_op_a),
        .rs_op_b   (rs_op_b),
        .rs_grant  (rs_grant),
        .flush     (flush),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .cdb_ready (cdb_ready),
        .busy      (busy)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic set_req(input int i, input logic [3:0] tag, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] prod);
        st_tag[i] = tag;
        st_a[i]   = a;
        st_b[i]   = b;
        st_exp[i] = prod;
        rs_req[i] = 1'b1;
    endtask

    // Called at posedge+1: checks this cycle's grant, books the expected result.
    task automatic tick(input logic [2:0] eg, input string nm);
        @(negedge clk);
        check(nm, 32'(rs_grant), 32'(eg));
        for (int i = 0; i < 3; i++)
            if (eg[i]) exp_q.push_back(exp_t'{st_tag[i], st_exp[i]});
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (eg[i]) begin
                if (sticky[i]) st_tag[i] = st_tag[i] + 4'd4;
                else           rs_req[i] = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(3'b000, "idle_grant");
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n && cdb_valid && !flush) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL cdb_unexpected: got tag %h data %h, required no result", cdb_tag, cdb_data);
            end else begin
                check("cdb_tag", 32'(cdb_tag), 32'(exp_q[0].tag));
                check("cdb_data", cdb_data, exp_q[0].data);
                if (cdb_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; cdb_ready = 1'b1; sticky = 3'b000;
        for (int i = 0; i < 3; i++) set_req(i, 4'(i), 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);

        // Reset state with all stations requesting
        @(negedge clk);
        check("rst_grant", 32'(rs_grant), 32'h0);
        check("rst_cdb_valid", 32'(cdb_valid), 32'h0);
        check("rst_cdb_tag", 32'(cdb_tag), 32'h0);
        check("rst_cdb_data", cdb_data, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        rs_req = 3'b000;

        // Single issue: latency of 3 cycles
        set_req(1, 4'd5, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000);
        tick(3'b010, "single_grant");
        check("lat_c1_valid", 32'(cdb_valid), 32'h0);
        tick(3'b000, "single_idle");
        check("lat_c2_valid", 32'(cdb_valid), 32'h0);
        tick(3'b000, "single_idle");
        check("lat_c3_valid", 32'(cdb_valid), 32'h1);
        idle(3);

        // Contention from reset: RS0, RS1, RS2, RS0
        do_reset();
        sticky = 3'b111;
        set_req(0, 4'd1, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000);
        set_req(1, 4'd2, 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000);
        set_req(2, 4'd3, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);
        tick(3'b001, "cont_g0");
        tick(3'b010, "cont_g1");
        tick(3'b100, "cont_g2");
        tick(3'b001, "cont_g3");
        sticky = 3'b000; rs_req = 3'b000;
        idle(5);

        // Backpressure: last_ptr=0, ready low in cycles 3-5
        sticky = 3'b111;
        set_req(0, 4'd8,  32'h4000_0000, 32'h4040_0000, 32'h40C0_0000);
        set_req(1, 4'd9,  32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000);
        set_req(2, 4'd10, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);
        tick(3'b010, "bp_g0");
        tick(3'b100, "bp_g1");
        tick(3'b001, "bp_g2");
        for (int c = 3; c <= 5; c++) begin
            cdb_ready = 1'b0;
            #1 check("bp_held_valid", 32'(cdb_valid), 32'h1);
            tick(3'b000, "bp_stall_grant");
        end
        cdb_ready = 1'b1;
        tick(3'b010, "bp_g3");
        sticky = 3'b000; rs_req = 3'b000;
        idle(6);

        // Special values and a negative product; last_ptr=1
        set_req(2, 4'd3, 32'h7F80_0000, 32'h0000_0000, 32'h7FFF_FFFF);
        set_req(0, 4'd4, 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000);
        tick(3'b100, "spec_g0");
        tick(3'b001, "spec_g1");
        set_req(1, 4'd6, 32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000);
        tick(3'b010, "spec_g2");
        idle(5);

        // Flush with results in flight and a delivery pending; last_ptr=1
        set_req(2, 4'd7, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);
        set_req(0, 4'd8, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000);
        set_req(1, 4'd9, 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000);
        tick(3'b100, "fl_g0");
        tick(3'b001, "fl_g1");
        tick(3'b010, "fl_g2");
        flush = 1'b1;
        exp_q.delete();
        set_req(0, 4'd10, 32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000);
        set_req(2, 4'd11, 32'h4080_0000, 32'h3F00_0000, 32'h4000_0000);
        tick(3'b000, "fl_flush_grant");
        flush = 1'b0;
        #1 check("fl_busy", 32'(busy), 32'h0);
        check("fl_cdb_valid", 32'(cdb_valid), 32'h0);
        tick(3'b100, "fl_after_g0");
        tick(3'b001, "fl_after_g1");
        idle(5);

        // Async reset with two operations in flight; last_ptr=0
        set_req(1, 4'd12, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000);
        set_req(2, 4'd13, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);
        tick(3'b010, "ar_g0");
        tick(3'b100, "ar_g1");
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1 check("ar_cdb_valid", 32'(cdb_valid), 32'h0);
        check("ar_busy", 32'(busy), 32'h0);
        set_req(0, 4'd14, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000);
        set_req(1, 4'd1, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);
        set_req(2, 4'd2, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);
        @(negedge clk);
        check("ar_grant_in_reset", 32'(rs_grant), 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick(3'b001, "ar_first_grant");
        rs_req = 3'b000;
        idle(5);

        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
